regf_arbiter: RTL and testbench
===============================

# regf_arbiter

Two-requester arbiter that shares the single-port register file between the command controller (requester 0) and a second master (requester 1, e.g. a debug/config port). It serialises accesses, drives the register file's Address/WrEn/RdEn/WrData as registered one-cycle pulses, and routes RdData back to the requester that issued the read. A read timeout guards against a missing RdData_Valid.

## Interface
- AW, 4, register file address width
- DW, 8, data width
- RD_TIMEOUT, 15, max cycles waited in RD_WAIT for RdData_Valid (≥1)
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- mN_req  in  1  request, N∈{0,1}; held high until mN_gnt
- mN_we  in  1  1 = write, 0 = read; stable while mN_req
- mN_addr  in  AW  access address; stable while mN_req
- mN_wdata  in  DW  write data; stable while mN_req
- mN_gnt  out  1  one-cycle pulse: request accepted and issued
- mN_rdata  out  DW  read data, valid with mN_rvalid
- mN_rvalid  out  1  one-cycle pulse: read complete
- mN_rerr  out  1  qualifies mN_rvalid: read timed out, mN_rdata = 0
- Address  out  AW  register file address
- WrEn  out  1  register file write strobe
- RdEn  out  1  register file read strobe
- WrData  out  DW  register file write data
- RdData  in  DW  register file read data
- RdData_Valid  in  1  register file read-data qualifier

## Operation
- States: IDLE, ISSUE, RD_WAIT.
- IDLE: if any mN_req, select winner, latch its we/addr/wdata and id, go ISSUE. No req: stay.
- ISSUE (one cycle): winner's mN_gnt=1; WrEn=we or RdEn=!we; Address/WrData from latch (WrData=0 on read). Write → IDLE; read → RD_WAIT, clear timeout counter.
- RD_WAIT: RdData_Valid → latch RdData, pulse winner's mN_rvalid with mN_rdata next cycle, rerr=0, → IDLE. Else counter++; counter reaching RD_TIMEOUT → pulse mN_rvalid with mN_rerr=1, rdata=0, → IDLE.
- RdData_Valid outside RD_WAIT ignored.
- Non-winner's outputs stay 0. Loser keeps req high and is served next arbitration.
- Requests sampled only in IDLE; req deassertion after capture is a protocol violation; captured access still completes.
- mN_rdata holds last read value until next rvalid to that requester.

## Timing
- Reset: all outputs 0; state IDLE; latches 0; last-grant pointer = 1 (requester 0 wins first).
- Req seen at edge k (IDLE) → gnt and strobe during cycle k+1.
- Write: 2 cycles per access; back-to-back writes every 2 cycles.
- Read: RdData_Valid at cycle j → mN_rvalid in cycle j+1.
- Timeout: rerr pulse exactly RD_TIMEOUT+1 cycles after the RdEn cycle.
- Simultaneous req: resolved per Configuration.
- Reset mid-operation: abort immediately, no gnt/rvalid emitted, strobes drop asynchronously.

## Configuration
- REGF_ARB_RR_EN defined: round-robin; on simultaneous req, grant requester ≠ last granted; pointer updates on every ISSUE.
- Undefined: fixed priority, requester 0 always wins; pointer logic absent. Single requests behave identically.

## Structure
- Package regf_arb_pkg: state encoding (IDLE, ISSUE, RD_WAIT), default AW/DW/RD_TIMEOUT constants, requester-id constants.
- Sub-module rr_arb2: combinational 2-way winner select plus registered last-grant pointer; compiled per REGF_ARB_RR_EN.
- Timeout counter width $clog2(RD_TIMEOUT+1).

## Test plan
- m0 write addr 3, data 0x5A → one cycle later m0_gnt=1, WrEn=1, Address=3, WrData=0x5A; back to IDLE; m1 outputs 0.
- m1 read addr 2, regfile returns 0x77 two cycles after RdEn → m1_rvalid one cycle after RdData_Valid, m1_rdata=0x77, m1_rerr=0.
- Both req held from reset with REGF_ARB_RR_EN → grants alternate m0,m1,m0,m1; without macro → m0 granted until m0_req drops, then m1.
- m0 read, RdData_Valid never asserted, RD_TIMEOUT=15 → m0_rvalid=1, m0_rerr=1, m0_rdata=0 16 cycles after RdEn; stray RdData_Valid afterward ignored.
- Reset asserted during RD_WAIT → all outputs 0 immediately; after release no rvalid; new m1 write served normally.

Source files
------------

// File: rtl/regf_arb_pkg.sv
// regf_arbiter shared types: FSM encoding, default sizes, requester ids.
// REGF_ARB_RR_EN selects round-robin arbitration (default: fixed priority).
package regf_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   localparam int AW_DEF         = 4;
   localparam int DW_DEF         = 8;
   localparam int RD_TIMEOUT_DEF = 15;

   localparam logic ID_M0 = 1'b0;
   localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/regf_arbiter_rr_arb2.sv
// Two-way winner select for regf_arbiter.
// REGF_ARB_RR_EN: round-robin with last-grant pointer; else requester 0 wins.
module rr_arb2
   import regf_arb_pkg::*;
(
   output logic       win,
   input  logic [1:0] req
`ifdef REGF_ARB_RR_EN
   ,
   input  logic       CLK,
   input  logic       RST,
   input  logic       upd,
   input  logic       upd_id
`endif
);

`ifdef REGF_ARB_RR_EN
   logic last;

   // starts at requester 1 so requester 0 wins the first tie
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         last <= ID_M1;
      end else if (upd) begin
         last <= upd_id;
      end
   end

   always_comb begin
      win = ID_M0;
      if (req == 2'b11) begin
         win = ~last;
      end else if (req[1]) begin
         win = ID_M1;
      end
   end
`else
   always_comb begin
      win = req[0] ? ID_M0 : ID_M1;
   end
`endif

endmodule

// File: rtl/regf_arbiter.sv
// Serialises two requesters onto a single-port register file.
// REGF_ARB_RR_EN: round-robin on simultaneous requests (else m0 priority).
module regf_arbiter
   import regf_arb_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rvalid,
   output logic          m0_rerr,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rvalid,
   output logic          m1_rerr,
   output logic [AW-1:0] Address,
   output logic          WrEn,
   output logic          RdEn,
   output logic [DW-1:0] WrData,
   input  logic [DW-1:0] RdData,
   input  logic          RdData_Valid
);

   localparam int CW = $clog2(RD_TIMEOUT + 1);

   state_t        state, state_n;
   logic          lat_we, lat_we_n;
   logic          lat_id, lat_id_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [1:0]    gnt, gnt_n;
   logic [1:0]    rv, rv_n;
   logic [1:0]    re, re_n;
   logic          wr, wr_n;
   logic          rd, rd_n;
   logic [AW-1:0] adr, adr_n;
   logic [DW-1:0] wd, wd_n;
   logic [DW-1:0] rd0, rd0_n;
   logic [DW-1:0] rd1, rd1_n;
   logic [1:0]    req;
   logic          win;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wd;

   assign req      = {m1_req, m0_req};
   assign sel_we   = win ? m1_we    : m0_we;
   assign sel_addr = win ? m1_addr  : m0_addr;
   assign sel_wd   = win ? m1_wdata : m0_wdata;
   assign cnt_inc  = cnt + 1'b1;

   rr_arb2 u_arb (
      .win    (win),
      .req    (req)
`ifdef REGF_ARB_RR_EN
      ,
      .CLK    (CLK),
      .RST    (RST),
      .upd    (state == ISSUE),
      .upd_id (lat_id)
`endif
   );

   // all strobes are registered: values computed here appear next cycle
   always_comb begin
      state_n  = state;
      lat_we_n = lat_we;
      lat_id_n = lat_id;
      cnt_n    = cnt;
      gnt_n    = '0;
      rv_n     = '0;
      re_n     = '0;
      wr_n     = 1'b0;
      rd_n     = 1'b0;
      adr_n    = '0;
      wd_n     = '0;
      rd0_n    = rd0;
      rd1_n    = rd1;
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_n     = ISSUE;
               lat_we_n    = sel_we;
               lat_id_n    = win;
               gnt_n[win]  = 1'b1;
               wr_n        = sel_we;
               rd_n        = ~sel_we;
               adr_n       = sel_addr;
               wd_n        = sel_we ? sel_wd : '0;
            end
         end
         ISSUE: begin
            state_n = lat_we ? IDLE : RD_WAIT;
            cnt_n   = '0;
         end
         RD_WAIT: begin
            if (RdData_Valid) begin
               state_n      = IDLE;
               rv_n[lat_id] = 1'b1;
               if (lat_id) rd1_n = RdData;
               else        rd0_n = RdData;
            end else if (cnt_inc == CW'(RD_TIMEOUT)) begin
               state_n      = IDLE;
               rv_n[lat_id] = 1'b1;
               re_n[lat_id] = 1'b1;
               if (lat_id) rd1_n = '0;
               else        rd0_n = '0;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state  <= IDLE;
         lat_we <= 1'b0;
         lat_id <= 1'b0;
         cnt    <= '0;
         gnt    <= '0;
         rv     <= '0;
         re     <= '0;
         wr     <= 1'b0;
         rd     <= 1'b0;
         adr    <= '0;
         wd     <= '0;
         rd0    <= '0;
         rd1    <= '0;
      end else begin
         state  <= state_n;
         lat_we <= lat_we_n;
         lat_id <= lat_id_n;
         cnt    <= cnt_n;
         gnt    <= gnt_n;
         rv     <= rv_n;
         re     <= re_n;
         wr     <= wr_n;
         rd     <= rd_n;
         adr    <= adr_n;
         wd     <= wd_n;
         rd0    <= rd0_n;
         rd1    <= rd1_n;
      end
   end

   assign m0_gnt    = gnt[0];
   assign m1_gnt    = gnt[1];
   assign m0_rvalid = rv[0];
   assign m1_rvalid = rv[1];
   assign m0_rerr   = re[0];
   assign m1_rerr   = re[1];
   assign m0_rdata  = rd0;
   assign m1_rdata  = rd1;
   assign WrEn      = wr;
   assign RdEn      = rd;
   assign Address   = adr;
   assign WrData    = wd;

endmodule

// File: tb/tb_regf_arbiter.sv
// Self-checking bench for regf_arbiter: directed cases plus random traffic
// against a transaction-level model (honours REGF_ARB_RR_EN).
module tb_regf_arbiter;

   localparam int T = 15;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [3:0] m0_addr = 0, m1_addr = 0;
   logic [7:0] m0_wdata = 0, m1_wdata = 0;
   logic       m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
   logic [7:0] m0_rdata, m1_rdata;
   logic [3:0] Address;
   logic       WrEn, RdEn;
   logic [7:0] WrData;
   logic [7:0] RdData = 0;
   logic       RdData_Valid = 0;

   int nvec = 0;
   int nerr = 0;

   regf_arbiter #(.AW(4), .DW(8), .RD_TIMEOUT(T)) dut (
      .CLK(CLK), .RST(RST),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
      .m0_rvalid(m0_rvalid), .m0_rerr(m0_rerr),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
      .m1_rvalid(m1_rvalid), .m1_rerr(m1_rerr),
      .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
      .RdData(RdData), .RdData_Valid(RdData_Valid)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit         busy, cur_we, cur_id, last;
   int         n, k;
   logic [1:0] e_gnt, e_rv, e_re;
   logic       e_wr, e_rde;
   logic [3:0] e_addr;
   logic [7:0] e_wd, e_rd0, e_rd1;

   function automatic void model_reset();
      busy = 0; cur_we = 0; cur_id = 0; last = 1; n = 0; k = 0;
      e_gnt = 0; e_rv = 0; e_re = 0; e_wr = 0; e_rde = 0;
      e_addr = 0; e_wd = 0; e_rd0 = 0; e_rd1 = 0;
   endfunction

   function automatic void respond(input bit id, input bit err,
                                   input logic [7:0] d);
      e_rv[id] = 1'b1;
      e_re[id] = err;
      if (id) e_rd1 = d;
      else    e_rd0 = d;
      busy = 0;
   endfunction

   // accepted at edge k: strobes in the period after k; a write frees the
   // arbiter at k+1; a read samples RdData_Valid at edges k+2..k+1+T
   function automatic void model_step();
      bit id;
      n++;
      e_gnt = 0; e_rv = 0; e_re = 0; e_wr = 0; e_rde = 0;
      e_addr = 0; e_wd = 0;
      if (busy) begin
         if (cur_we) busy = 0;
         else if (n >= k + 2) begin
            if (RdData_Valid)     respond(cur_id, 0, RdData);
            else if (n == k+1+T)  respond(cur_id, 1, 8'h00);
         end
      end else if (m0_req || m1_req) begin
`ifdef REGF_ARB_RR_EN
         id = (m0_req && m1_req) ? !last : m1_req;
         last = id;
`else
         id = !m0_req;
`endif
         busy = 1; k = n; cur_id = id;
         cur_we = id ? m1_we : m0_we;
         e_gnt[id] = 1'b1;
         e_wr = cur_we;
         e_rde = !cur_we;
         e_addr = id ? m1_addr : m0_addr;
         e_wd = cur_we ? (id ? m1_wdata : m0_wdata) : 8'h00;
      end
   endfunction

   function automatic logic [63:0] outs();
      return {28'd0, m1_gnt, m0_gnt, WrEn, RdEn, Address, WrData,
              m1_rvalid, m0_rvalid, m1_rerr, m0_rerr, m1_rdata, m0_rdata};
   endfunction

   function automatic logic [63:0] exp_vec();
      return {28'd0, e_gnt, e_wr, e_rde, e_addr, e_wd,
              e_rv, e_re, e_rd1, e_rd0};
   endfunction

   always @(negedge RST) model_reset();

   always @(posedge CLK) begin
      if (RST) model_step();
      #1;
      if (RST) chk("cycle", outs(), exp_vec());
   end

   // ---------------- directed helpers ----------------
   task automatic issue(input bit id, input bit we, input logic [3:0] a,
                        input logic [7:0] d);
      int t = 0;
      if (id) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
      else    begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
      do begin
         @(negedge CLK);
         t++;
      end while (!(id ? m1_gnt : m0_gnt) && t < 40);
      chk("gnt", {m1_gnt, m0_gnt}, id ? 2'b10 : 2'b01);
      chk("strobe", {WrEn, RdEn}, we ? 2'b10 : 2'b01);
      chk("addr", Address, a);
      chk("wdata", WrData, we ? d : 8'h00);
      if (id) m1_req = 0;
      else    m0_req = 0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge CLK);
      chk("reset_outs", outs(), 64'd0);
      RST = 1;

      // write m0 addr 3 data 5A
      issue(0, 1, 4'd3, 8'h5A);
      @(negedge CLK);
      chk("wr_done", {m1_gnt, m0_gnt, WrEn, RdEn}, 4'b0000);

      // m1 read addr 2, data 77 two cycles after RdEn
      issue(1, 0, 4'd2, 8'hEE);
      @(negedge CLK);
      @(negedge CLK);
      RdData_Valid = 1; RdData = 8'h77;
      @(negedge CLK);
      RdData_Valid = 0; RdData = 8'h00;
      chk("m1_rd", {m1_rvalid, m1_rerr, m1_rdata, m0_rvalid}, {2'b10, 8'h77, 1'b0});

      // m0 read with earliest response
      issue(0, 0, 4'd7, 8'h00);
      @(negedge CLK);
      RdData_Valid = 1; RdData = 8'hA5;
      @(negedge CLK);
      RdData_Valid = 0;
      chk("m0_rd", {m0_rvalid, m0_rerr, m0_rdata}, {2'b10, 8'hA5});

      // m0 read timeout
      issue(0, 0, 4'd5, 8'h00);
      for (int i = 2; i <= T + 1; i++) begin
         @(negedge CLK);
         chk("to_quiet", m0_rvalid, 1'b0);
      end
      @(negedge CLK);
      chk("timeout", {m0_rvalid, m0_rerr, m0_rdata}, {2'b11, 8'h00});
      RdData_Valid = 1; RdData = 8'hFF;
      @(negedge CLK);
      RdData_Valid = 0;
      chk("stray", {m0_rvalid, m1_rvalid, m0_rdata}, 10'd0);

      // reset during RD_WAIT
      issue(1, 0, 4'd4, 8'h00);
      @(negedge CLK);
      RdData_Valid = 1; RdData = 8'h99;
      #1 RST = 0;
      #1 chk("rst_async", outs(), 64'd0);
      @(negedge CLK);
      RdData_Valid = 0;
      RST = 1;
      repeat (3) begin
         @(negedge CLK);
         chk("rst_norv", {m0_rvalid, m1_rvalid}, 2'b00);
      end
      issue(1, 1, 4'd9, 8'h3C);
      @(negedge CLK);

      // both requesting from reset
      RST = 0;
      m0_req = 1; m0_we = 1; m0_addr = 4'd1; m0_wdata = 8'h11;
      m1_req = 1; m1_we = 1; m1_addr = 4'd2; m1_wdata = 8'h22;
      @(negedge CLK);
      RST = 1;
      for (int i = 0; i < 5; i++) begin
         int t = 0;
         do begin
            @(negedge CLK);
            t++;
         end while (!(m0_gnt || m1_gnt) && t < 10);
`ifdef REGF_ARB_RR_EN
         chk("arb_order", {m1_gnt, m0_gnt}, (i % 2) ? 2'b10 : 2'b01);
`else
         chk("arb_order", {m1_gnt, m0_gnt}, (i == 4) ? 2'b10 : 2'b01);
`endif
         if (i == 3) m0_req = 0;
      end
      m0_req = 0; m1_req = 0;
      @(negedge CLK);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge CLK);
         if (m0_req && m0_gnt) m0_req = 0;
         if (m1_req && m1_gnt) m1_req = 0;
         if (!m0_req && $urandom_range(2) == 0) begin
            m0_req = 1; m0_we = 1'($urandom);
            m0_addr = 4'($urandom); m0_wdata = 8'($urandom);
         end
         if (!m1_req && $urandom_range(2) == 0) begin
            m1_req = 1; m1_we = 1'($urandom);
            m1_addr = 4'($urandom); m1_wdata = 8'($urandom);
         end
         RdData_Valid = ($urandom_range(7) == 0);
         RdData = 8'($urandom);
         if ($urandom_range(799) == 0) begin
            #1 RST = 0;
            @(negedge CLK);
            RST = 1;
         end
      end
      m0_req = 0; m1_req = 0; RdData_Valid = 0;
      repeat (3) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
